// File: rtl/seq_multiplier_ctrl.sv
// Purpose: 4-bit ripple adder/subtractor, the only arithmetic resource of the multiplier.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module four_bit_adder_subtractor (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       subtract,
    output logic [3:0] Result,
    output logic       Cout
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    always_comb begin
        b_eff = B ^ {4{subtract}};
        sum   = {1'b0, A} + {1'b0, b_eff} + {4'b0000, subtract};
    end

    assign Result = sum[3:0];
    assign Cout   = sum[4];

endmodule

// Purpose: unsigned WIDTHxWIDTH shift-and-add multiplier sequenced around one shared adder.
// Latency: done pulses in the cycle after the 4th CALC edge; back in IDLE 5 edges after start.
// Backpressure: start is only sampled in IDLE; requests during CALC/DONE are dropped, not queued.
module seq_multiplier_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     add_result;
    logic                 add_cout;
    logic                 c_sel;
    logic [WIDTH-1:0]     s_sel;

    four_bit_adder_subtractor u_adder (
        .A        (acc_q),
        .B        (m_q),
        .subtract (1'b0),
        .Result   (add_result),
        .Cout     (add_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        c_sel   = 1'b0;
        s_sel   = acc_q;

        // Add M only when the current multiplier bit is set; the carry always joins the shift.
        if (q_q[0]) begin
            c_sel = add_cout;
            s_sel = add_result;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                {acc_d, q_d} = {c_sel, s_sel, q_q[WIDTH-1:1]};
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == 3'd3) begin
                    p_d     = {acc_d, q_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they stay glitch-free Moore outputs.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Scoreboarded random/directed bench for seq_multiplier_ctrl; products come from plain A*B.
module tb_seq_multiplier_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int tests  = 0;
    int failed = 0;

    // Reference: an accepted request occupies the block for 5 cycles; done in the last one.
    int         remaining = 0;
    int         n_issued  = 0;
    int         n_done    = 0;
    logic [7:0] exp_q[$];

    seq_multiplier_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (a_in),
        .B       (b_in),
        .busy    (busy),
        .done    (done),
        .P       (p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining = 0;
            exp_q.delete();
        end else if (remaining == 0) begin
            if (start) begin
                exp_q.push_back({4'b0000, a_in} * {4'b0000, b_in});
                n_issued++;
                remaining = 5;
            end
        end else begin
            remaining--;
        end
    end

    always @(negedge clk) begin
        check("busy", {7'b0, busy}, {7'b0, (remaining > 0)});
        check("done", {7'b0, done}, {7'b0, (remaining == 1)});
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("done_without_request", 8'd1, 8'd0);
            end else begin
                check("product", p, exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = 4'($urandom_range(0, 15));
        b_in  = 4'($urandom_range(0, 15));
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {7'b0, seen}, 8'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        a_in    = 4'd0;
        b_in    = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {7'b0, busy}, 8'd0);
        check("reset_done", {7'b0, done}, 8'd0);
        check("reset_p", p, 8'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort mid-calculation with an asynchronous reset between edges.
        @(negedge clk);
        a_in  = 4'd7;
        b_in  = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_busy", {7'b0, busy}, 8'd0);
        check("midreset_done", {7'b0, done}, 8'd0);
        check("midreset_p", p, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        do_op(4'd3, 4'd5);
        check("after_reset_p", p, 8'h0F);

        do_op(4'hF, 4'hF);
        check("max_p", p, 8'hE1);
        do_op(4'd0, 4'd9);
        do_op(4'd9, 4'd0);
        do_op(4'd1, 4'd1);
        do_op(4'd8, 4'd2);
        check("eight_times_two", p, 8'h10);

        // A second request during CALC must be ignored.
        @(negedge clk);
        a_in  = 4'd7;
        b_in  = 4'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = 4'd2;
        b_in  = 4'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("ignored_start_p", p, 8'h2A);

        // start held high: operands swapped in the done cycle of the first operation.
        @(negedge clk);
        a_in  = 4'd7;
        b_in  = 4'd3;
        start = 1'b1;
        wait_done("b2b_first_done");
        check("b2b_first_p", p, 8'h15);
        a_in = 4'd12;
        b_in = 4'd11;
        wait_done("b2b_second_done");
        check("b2b_second_p", p, 8'h84);
        start = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            a_in  = 4'($urandom_range(0, 15));
            b_in  = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 256; v++) begin
            do_op(4'(v >> 4), 4'(v));
        end

        repeat (10) @(negedge clk);
        check("queue_empty", 8'(exp_q.size()), 8'd0);
        check("done_count", 8'(n_done), 8'(n_issued - 1));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
